// File: rtl/shift_sequencer.sv
// Round-robin front end that runs a single-bit shift unit N times per request.
// Define SHIFT_SEQ_ROTATE_EN to honour mode[1] as rotate; otherwise every request is a logical shift.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [CNT_W-1:0] req0_amt,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [CNT_W-1:0] req1_amt,
    input  logic [1:0]       req1_mode,
    output logic [WIDTH-1:0] shu_a,
    output logic [WIDTH-1:0] shu_b,
    output logic [1:0]       shu_fun,
    output logic             shu_enable,
    input  logic [WIDTH-1:0] shu_out,
    input  logic             shu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIDTH_AMT = CNT_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             cur_id;
    logic             prio;

    logic             sel;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic [CNT_W-1:0] sel_amt;
    logic             sel_dir;
    logic             sel_clamp;
    logic [WIDTH-1:0] step;
    logic [CNT_W-1:0] cnt_dec;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot;
    logic sel_rot;
`else
    logic unused_mode;
    assign unused_mode = req0_mode[1] ^ req1_mode[1];
`endif

    // The ready pulse registered last cycle marks which requester is being captured now.
    always_comb begin
        sel       = req1_ready;
        sel_valid = sel ? req1_valid   : req0_valid;
        sel_data  = sel ? req1_data    : req0_data;
        sel_amt   = sel ? req1_amt     : req0_amt;
        sel_dir   = sel ? req1_mode[0] : req0_mode[0];
        cnt_dec   = cnt - CNT_ONE;
        step      = shu_out;
`ifdef SHIFT_SEQ_ROTATE_EN
        sel_rot   = sel ? req1_mode[1] : req0_mode[1];
        sel_clamp = !sel_rot && (sel_amt >= WIDTH_AMT);
        if (rot)
            step = dir ? (shu_out | {{(WIDTH-1){1'b0}}, work[WIDTH-1]})
                       : (shu_out | {work[0], {(WIDTH-1){1'b0}}});
`else
        sel_clamp = sel_amt >= WIDTH_AMT;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            cnt        <= '0;
            dir        <= 1'b0;
            cur_id     <= 1'b0;
            prio       <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            shu_enable <= 1'b0;
            shu_fun    <= 2'b00;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot        <= 1'b0;
`endif
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            shu_enable <= 1'b0;
            shu_fun    <= 2'b00;
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        if (sel_valid) begin
                            work   <= sel_data;
                            cnt    <= sel_amt;
                            dir    <= sel_dir;
                            cur_id <= sel;
                            prio   <= ~sel;
`ifdef SHIFT_SEQ_ROTATE_EN
                            rot    <= sel_rot;
`endif
                            if (sel_amt == '0) begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_id    <= sel;
                            end else if (sel_clamp) begin
                                work      <= '0;
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_id    <= sel;
                            end else begin
                                state      <= ISSUE;
                                shu_enable <= 1'b1;
                                shu_fun    <= {1'b0, sel_dir};
                            end
                        end
                    end else if (req0_valid && (!req1_valid || !prio)) begin
                        req0_ready <= 1'b1;
                    end else if (req1_valid) begin
                        req1_ready <= 1'b1;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (shu_flag) begin
                        work <= step;
                        cnt  <= cnt_dec;
                        if (cnt_dec == '0) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_id    <= cur_id;
                        end else begin
                            state      <= ISSUE;
                            shu_enable <= 1'b1;
                            shu_fun    <= {1'b0, dir};
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_id    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and result both live in work; gating keeps them at zero outside their windows.
    assign shu_a    = shu_enable ? work : '0;
    assign shu_b    = '0;
    assign rsp_data = rsp_valid ? work : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural 1-cycle shift unit.
module tb_shift_sequencer;
    localparam int W = 16;
    localparam int CW = 5;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct packed {
        logic          id;
        logic [W-1:0]  data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_data, req1_data;
    logic [CW-1:0] req0_amt, req1_amt;
    logic [1:0]    req0_mode, req1_mode;
    logic [W-1:0]  shu_a, shu_b;
    logic [1:0]    shu_fun;
    logic          shu_enable;
    logic [W-1:0]  shu_out = '0;
    logic          shu_flag = 1'b0;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [W-1:0]  rsp_data;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_mode(req1_mode),
        .shu_a(shu_a), .shu_b(shu_b), .shu_fun(shu_fun), .shu_enable(shu_enable),
        .shu_out(shu_out), .shu_flag(shu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-bit shift unit: samples enable at an edge, result and flag valid after it.
    always @(posedge clk) begin
        if (shu_enable) begin
            shu_out  <= shu_fun[0] ? (shu_a << 1) : (shu_a >> 1);
            shu_flag <= 1'b1;
        end else begin
            shu_out  <= '0;
            shu_flag <= 1'b0;
        end
    end

    function automatic logic [55:0] outs();
        return {req0_ready, req1_ready, shu_a, shu_b, shu_fun, shu_enable,
                rsp_valid, rsp_data, rsp_id, busy};
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [CW-1:0] a,
                                           input logic [1:0] m);
        logic [W-1:0] r;
        logic         rot;
        rot = ROT && m[1];
        r = d;
        if (!rot && a >= 5'd16) return '0;
        for (int i = 0; i < int'(a); i++)
            r = m[0] ? {r[W-2:0], rot & r[W-1]} : {rot & r[0], r[W-1:1]};
        return r;
    endfunction

    function automatic bit fast(input logic [CW-1:0] a, input logic [1:0] m);
        return (a == '0) || (!(ROT && m[1]) && a >= 5'd16);
    endfunction

    function automatic int exp_lat(input logic [CW-1:0] a, input logic [1:0] m);
        return fast(a, m) ? 1 : 1 + 2 * int'(a);
    endfunction

    function automatic int exp_en(input logic [CW-1:0] a, input logic [1:0] m);
        return fast(a, m) ? 0 : int'(a);
    endfunction

    task automatic drive(input logic id, input logic v, input logic [W-1:0] d,
                         input logic [CW-1:0] a, input logic [1:0] m);
        if (id) begin
            req1_valid = v; req1_data = d; req1_amt = a; req1_mode = m;
        end else begin
            req0_valid = v; req0_data = d; req0_amt = a; req0_mode = m;
        end
    endtask

    // Drives one request, waits for the grant and the response; counts latency from the grant.
    task automatic run_req(input logic id, input logic [W-1:0] d, input logic [CW-1:0] a,
                           input logic [1:0] m, output logic to, output logic [W-1:0] od,
                           output logic oid, output int lat, output int en);
        int w;
        to = 1'b0; od = '0; oid = 1'b0; lat = 0; en = 0; w = 0;
        @(negedge clk);
        drive(id, 1'b1, d, a, m);
        while (!(id ? req1_ready : req0_ready)) begin
            if (w == 50) begin
                to = 1'b1;
                drive(id, 1'b0, '0, '0, '0);
                return;
            end
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        drive(id, 1'b0, '0, '0, '0);
        lat = 1;
        while (!rsp_valid) begin
            if (lat == 200) begin
                to = 1'b1;
                return;
            end
            if (shu_enable) en++;
            @(negedge clk);
            lat++;
        end
        od = rsp_data;
        oid = rsp_id;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b1, 16'hFFFF, 5'd3, 2'b01);
        repeat (3) @(negedge clk);
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL reset_hold outs: got %h want 0", outs());
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL reset_idle outs: got %h want 0", outs());
        end
    endtask

    task automatic test_shift;
        logic          ti [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0]  td [4] = '{16'h00F0, 16'h8000, 16'hA5A5, 16'hFFFF};
        logic [CW-1:0] ta [4] = '{5'd4, 5'd15, 5'd1, 5'd15};
        logic [1:0]    tm [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
        exp_t e; logic to; logic [W-1:0] od; logic oid; int lat, en;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{ti[i], model(td[i], ta[i], tm[i])});
            run_req(ti[i], td[i], ta[i], tm[i], to, od, oid, lat, en);
            e = sb.pop_front();
            total++;
            if ({to, od, oid} !== {1'b0, e.data, e.id}) begin
                bad++; $display("FAIL shift[%0d] rsp: got to=%0b data=%h id=%0b want data=%h id=%0b",
                                i, to, od, oid, e.data, e.id);
            end
            total++;
            if (lat !== exp_lat(ta[i], tm[i]) || en !== exp_en(ta[i], tm[i])) begin
                bad++; $display("FAIL shift[%0d] timing: got lat=%0d en=%0d want lat=%0d en=%0d",
                                i, lat, en, exp_lat(ta[i], tm[i]), exp_en(ta[i], tm[i]));
            end
        end
    endtask

    task automatic test_arbitration;
        exp_t e; int w; logic exp_id; logic [W-1:0] d0, d1;
        for (int r = 0; r < 4; r++) begin
            d0 = 16'h0011 << r;
            d1 = 16'h0300 << r;
            exp_id = r[0];
            sb.push_back('{exp_id, model(exp_id ? d1 : d0, 5'd1, 2'b01)});
            @(negedge clk);
            drive(1'b0, 1'b1, d0, 5'd1, 2'b01);
            drive(1'b1, 1'b1, d1, 5'd1, 2'b01);
            w = 0;
            while (!(req0_ready || req1_ready) && w < 50) begin @(negedge clk); w++; end
            total++;
            if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL arb[%0d] grant: got ready=%b%b want id=%0b",
                                r, req1_ready, req0_ready, exp_id);
            end
            @(negedge clk);
            drive(1'b0, 1'b0, '0, '0, '0);
            drive(1'b1, 1'b0, '0, '0, '0);
            while (!rsp_valid && w < 200) begin @(negedge clk); w++; end
            e = sb.pop_front();
            total++;
            if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, e.data, e.id}) begin
                bad++; $display("FAIL arb[%0d] rsp: got v=%0b data=%h id=%0b want data=%h id=%0b",
                                r, rsp_valid, rsp_data, rsp_id, e.data, e.id);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fast_path;
        logic          ti [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0]  td [4] = '{16'hBEEF, 16'hFFFF, 16'hFFFF, 16'h1234};
        logic [CW-1:0] ta [4] = '{5'd0, 5'd20, 5'd16, 5'd0};
        logic [1:0]    tm [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        exp_t e; logic to; logic [W-1:0] od; logic oid; int lat, en;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{ti[i], model(td[i], ta[i], tm[i])});
            run_req(ti[i], td[i], ta[i], tm[i], to, od, oid, lat, en);
            e = sb.pop_front();
            total++;
            if ({to, od, oid} !== {1'b0, e.data, e.id}) begin
                bad++; $display("FAIL fast[%0d] rsp: got to=%0b data=%h id=%0b want data=%h id=%0b",
                                i, to, od, oid, e.data, e.id);
            end
            total++;
            if (lat !== 1 || en !== 0) begin
                bad++; $display("FAIL fast[%0d] timing: got lat=%0d en=%0d want lat=1 en=0", i, lat, en);
            end
        end
    endtask

    task automatic test_mode;
        logic          ti [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0]  td [3] = '{16'h8001, 16'h8001, 16'h8001};
        logic [CW-1:0] ta [3] = '{5'd1, 5'd1, 5'd20};
        logic [1:0]    tm [3] = '{2'b11, 2'b10, 2'b11};
        exp_t e; logic to; logic [W-1:0] od; logic oid; int lat, en;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{ti[i], model(td[i], ta[i], tm[i])});
            run_req(ti[i], td[i], ta[i], tm[i], to, od, oid, lat, en);
            e = sb.pop_front();
            total++;
            if ({to, od, oid} !== {1'b0, e.data, e.id}) begin
                bad++; $display("FAIL mode[%0d] rsp: got to=%0b data=%h id=%0b want data=%h id=%0b",
                                i, to, od, oid, e.data, e.id);
            end
            total++;
            if (lat !== exp_lat(ta[i], tm[i]) || en !== exp_en(ta[i], tm[i])) begin
                bad++; $display("FAIL mode[%0d] timing: got lat=%0d en=%0d want lat=%0d en=%0d",
                                i, lat, en, exp_lat(ta[i], tm[i]), exp_en(ta[i], tm[i]));
            end
        end
    endtask

    task automatic test_backpressure;
        exp_t e; int w; logic stable; int pulses;
        rsp_ready = 1'b0;
        sb.push_back('{1'b1, model(16'h1234, 5'd3, 2'b01)});
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h1234, 5'd3, 2'b01);
        w = 0;
        while (!req1_ready && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, '0);
        while (!rsp_valid && w < 200) begin @(negedge clk); w++; end
        e = sb.pop_front();
        total++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, e.data, e.id}) begin
            bad++; $display("FAIL bp rsp: got v=%0b data=%h id=%0b want data=%h id=%0b",
                            rsp_valid, rsp_data, rsp_id, e.data, e.id);
        end
        drive(1'b0, 1'b1, 16'h00FF, 5'd0, 2'b00);
        stable = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id) stable = 1'b0;
            if (req0_ready || req1_ready) pulses++;
        end
        total++;
        if (stable !== 1'b1) begin
            bad++; $display("FAIL bp hold: got data=%h id=%0b want data=%h id=%0b",
                            rsp_data, rsp_id, e.data, e.id);
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL bp ready: got %0d grant pulses want 0", pulses);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000) begin
            bad++; $display("FAIL bp accept: got busy=%0b v=%0b rdy=%b%b want all 0",
                            busy, rsp_valid, req1_ready, req0_ready);
        end
        sb.push_back('{1'b0, model(16'h00FF, 5'd0, 2'b00)});
        w = 0;
        while (!req0_ready && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        while (!rsp_valid && w < 200) begin @(negedge clk); w++; end
        e = sb.pop_front();
        total++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, e.data, e.id}) begin
            bad++; $display("FAIL bp next: got v=%0b data=%h id=%0b want data=%h id=%0b",
                            rsp_valid, rsp_data, rsp_id, e.data, e.id);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        exp_t e; int w; logic to; logic [W-1:0] od; logic oid; int lat, en;
        sb.push_back('{1'b0, model(16'h0001, 5'd10, 2'b01)});
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0001, 5'd10, 2'b01);
        w = 0;
        while (!req0_ready && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        total++;
        if ({busy, shu_enable, rsp_valid} !== 3'b100) begin
            bad++; $display("FAIL midrst wait: got busy=%0b en=%0b v=%0b want 1 0 0",
                            busy, shu_enable, rsp_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_front());
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL midrst outs: got %h want 0", outs());
        end
        rst = 1'b0;
        sb.push_back('{1'b1, model(16'h0003, 5'd2, 2'b01)});
        run_req(1'b1, 16'h0003, 5'd2, 2'b01, to, od, oid, lat, en);
        e = sb.pop_front();
        total++;
        if ({to, od, oid, lat} !== {1'b0, e.data, e.id, 32'd5}) begin
            bad++; $display("FAIL midrst after: got to=%0b data=%h id=%0b lat=%0d want data=%h id=%0b lat=5",
                            to, od, oid, lat, e.data, e.id);
        end
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        test_reset();
        test_shift();
        test_arbitration();
        test_fast_path();
        test_mode();
        test_backpressure();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-bit shift controller in front of the single-bit `Shift_Unit` datapath. It arbitrates round-robin between two requesters and iterates the 1-bit shifter N times, feeding each result back as the next operand. It returns the final word with the requester ID over a valid/ready response port. It sits between the ALU issue logic and the shift unit and owns that unit's `A`, `B`, `ALU_FUN` and `Shift_Enable` inputs exclusively.

## Interface
- `WIDTH`, 16, data width; must match the shift unit
- `CNT_W`, 5, shift-amount field width; 2^CNT_W-1 ≥ WIDTH
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous, active-high reset
- `req0_valid` / `req1_valid` in 1, request pending
- `req0_ready` / `req1_ready` out 1, one-cycle grant pulse; handshake = valid & ready
- `req0_data` / `req1_data` in WIDTH, operand
- `req0_amt` / `req1_amt` in CNT_W, shift count
- `req0_mode` / `req1_mode` in 2, bit0 = direction (0 right, 1 left); bit1 = rotate (see Configuration)
- `shu_a` out WIDTH, to shift unit `A`
- `shu_b` out WIDTH, to shift unit `B`; constant 0
- `shu_fun` out 2, to shift unit `ALU_FUN`: 00 = A>>1, 01 = A<<1
- `shu_enable` out 1, to `Shift_Enable`
- `shu_out` in WIDTH, from `Shift_OUT`
- `shu_flag` in 1, from `Shift_Flag`
- `rsp_valid` out 1, result available
- `rsp_ready` in 1, consumer accepts
- `rsp_data` out WIDTH, shifted result
- `rsp_id` out 1, granted requester index
- `busy` out 1, high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `reqN_valid` is high, grant one requester and pulse its `ready`.
  - Capture data, amt, mode and ID into working registers.
  - Arbitration is round-robin: priority goes to the requester not granted last. When only one requester is valid, it wins.
  - Next state:
    - amt = 0 → DONE; result = operand.
    - Logical shift with amt ≥ WIDTH → DONE; result = 0; the shift unit is not used.
    - Otherwise → ISSUE.
- ISSUE:
  - `shu_enable`=1, `shu_a`=work, `shu_fun`={1'b0, dir}.
  - Go to WAIT.
- WAIT:
  - `shu_enable`=0.
  - When `shu_flag`=1: work ← `shu_out`; for rotate, OR in the bit shifted out (the old work[0] into MSB for right, the old work[WIDTH-1] into LSB for left); amt ← amt-1.
  - If the new amt = 0 → DONE, else → ISSUE.
  - If `shu_flag`=0, remain in WAIT with no state change.
- DONE:
  - `rsp_valid`=1; `rsp_data` and `rsp_id` are stable until `rsp_ready`=1.
  - On acceptance → IDLE.
  - No new grant is issued in the acceptance cycle.
- Outside ISSUE, `shu_enable`=0, `shu_a`=0 and `shu_fun`=00.
- Rotate does not clamp: every count iterates fully, up to 2^CNT_W-1 steps.

## Timing
- Reset values:
  - Every output is 0.
  - FSM = IDLE.
  - Round-robin pointer favours req0.
  - Working registers are 0.
- Shift-unit round trip is 1 cycle: enable sampled at edge t, `shu_flag`/`shu_out` valid after edge t, consumed at edge t+1.
- Logical or rotate latency, amt = N ≥ 1, grant at edge g: `rsp_valid` is high after edge g+1+2N. Each bit costs 2 cycles.
- Fast paths (amt = 0, or logical amt ≥ WIDTH): `rsp_valid` is high after edge g+1.
- Minimum spacing between grants: response-accept cycle + 1 IDLE cycle.
- `rsp_ready` held 0 keeps the FSM in DONE indefinitely; requesters see `ready`=0 during this time.
- Simultaneous valid on both requesters in IDLE: exactly one `ready` pulses, and the other requester wins the next arbitration.
- Mid-operation `rst`: the FSM returns to IDLE on that edge, `rsp_valid` drops, the pending result is discarded, and `shu_enable`=0.

## Configuration
- `SHIFT_SEQ_ROTATE_EN` defined:
  - `mode[1]`=1 selects rotate, with bit re-insertion as in Operation.
- Not defined:
  - `mode[1]` is ignored; every request is a logical shift.
  - The rotate logic is absent.
  - The logical-shift clamp applies to all requests.

## Test plan
- Reset, then req0 with data=16'h00F0, amt=4, mode=01 → `rsp_data`=16'h0F00, `rsp_id`=0, `rsp_valid` 9 cycles after grant, `shu_enable` pulsed 4 times.
- req0 and req1 valid together, repeated 4 times → grant order 0,1,0,1; each `rsp_id` matches the granted requester.
- amt=0 returns the operand unchanged after 1 cycle; logical amt=20 on 16'hFFFF → 0 after 1 cycle with `shu_enable` never asserted.
- `rsp_ready` held low 5 cycles after `rsp_valid` → data/ID stable, no new `ready` pulse, then acceptance → IDLE.
- `rst` asserted in WAIT during a 10-bit shift → next cycle all outputs are 0; a new request then completes correctly.
- With `SHIFT_SEQ_ROTATE_EN`: 16'h8001, amt=1, mode=11 → 16'h0003; mode=10 → 16'hC000.
